water_plant_model: RTL
======================

Name: water_plant_model

Overview:
- Sensor-side plant model for the irrigation controller. It closes the loop on hardware: it consumes the controller's actuator outputs (supply valve, sprinkler pump, dripper valve) and produces the water-level and earth-humidity sensor inputs the controller reads.
- State is a tank-level accumulator, a soil-moisture accumulator and a step prescaler.
- Fault injection drives inconsistent level sensors so the controller's alarm path can be exercised.

Parameters:
- LEVEL_WIDTH, 8, width of the tank level accumulator. Maximum level is 2^LEVEL_WIDTH-1.
- MOISTURE_WIDTH, 8, width of the soil moisture accumulator.
- INITIAL_LEVEL, 0, tank level loaded on reset.
- LOW_THRESHOLD, 32, level at or above which low_water_level is 1.
- MID_THRESHOLD, 128, level at or above which mid_water_level is 1.
- HIGH_THRESHOLD, 224, level at or above which high_water_level is 1.
- WET_THRESHOLD, 100, moisture at or above which earth_humidity is 1.
- FILL_RATE, 4, level added per step while the supply valve is open.
- SPRINKLER_DRAIN, 3, level removed per step while the sprinkler runs.
- DRIPPER_DRAIN, 1, level removed per step while the dripper is open.
- SPRINKLER_WET, 5, moisture added per step by the sprinkler.
- DRIPPER_WET, 2, moisture added per step by the dripper.
- DRY_RATE, 1, moisture removed per step when nothing is wetting the soil.
- STEP_DIVIDER, 4, clock cycles per simulation step. Must be at least 1.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = simulation advances; 0 = freeze all state.
- water_supply_valvule  in  1  supply valve command from the controller.
- splinker_bomb  in  1  sprinkler pump command.
- dripper_valvule  in  1  dripper valve command.
- fault_mode  in  2  0 none; 1 high sensor stuck at 1; 2 low sensor stuck at 0; 3 mid sensor stuck at 0.
- low_water_level  out  1  level sensor output.
- mid_water_level  out  1  level sensor output.
- high_water_level  out  1  level sensor output.
- earth_humidity  out  1  soil-wet sensor output.
- step  out  1  one-cycle pulse on each simulation step.
- level  out  LEVEL_WIDTH  current tank level, for display and debug.
- moisture  out  MOISTURE_WIDTH  current soil moisture.

Behaviour:
- Reset values:
  - level = INITIAL_LEVEL; moisture = 0; prescaler = 0.
  - step = 0.
  - All four sensor outputs = 0.
  - Reset wins over every other input. Reset mid-run takes effect at the next edge.
- Prescaler:
  - While run=1 it counts 0..STEP_DIVIDER-1 and wraps to 0.
  - The step event occurs on the cycle the count equals STEP_DIVIDER-1. The step output is registered and goes high in the cycle after that event, for exactly one cycle.
  - While run=0 the prescaler, level and moisture hold their values, and step is 0.
- Actuator commands are sampled only at the step event. Commands that toggle between steps have no effect.
- Level update at the step event:
  - next = level + (valve ? FILL_RATE : 0) - (sprinkler ? SPRINKLER_DRAIN : 0) - (dripper ? DRIPPER_DRAIN : 0).
  - Computed signed in LEVEL_WIDTH+2 bits.
  - Saturates to 0 below and to 2^LEVEL_WIDTH-1 above. It never wraps.
- Moisture update at the same step event:
  - wet = (sprinkler ? SPRINKLER_WET : 0) + (dripper ? DRIPPER_WET : 0).
  - Wetting counts only if the pre-update level is nonzero (an empty tank delivers no water).
  - If the effective wet is nonzero, moisture += wet; otherwise moisture -= DRY_RATE.
  - Saturates at 0 and at 2^MOISTURE_WIDTH-1.
- Sensors:
  - Registered every cycle from the current level and moisture (one-cycle latency after a level or moisture change), regardless of run.
  - Raw value: low = level >= LOW_THRESHOLD; mid = level >= MID_THRESHOLD; high = level >= HIGH_THRESHOLD; earth = moisture >= WET_THRESHOLD.
  - fault_mode then overrides exactly one level sensor.
  - fault_mode is also sampled every cycle, so a change appears at the outputs one cycle later.
  - earth_humidity is never faulted.
- Simultaneous valve + sprinkler + dripper with default rates gives a net level change of 0.
- Parameter ordering LOW_THRESHOLD ≤ MID_THRESHOLD ≤ HIGH_THRESHOLD is required. Its violation is not checked.

Test Plan:
- Reset, run=1, valve=1 only:
  - level reads 4 after the first step and 32 after step 8; low_water_level rises one cycle after level reaches 32.
  - high_water_level rises at step 56 (level 224); level saturates at 255 at step 64, not 0.
- Level 255, sprinkler=1 only:
  - level drops 3 per step and moisture rises 5 per step.
  - high_water_level falls at step 11 (level 222); earth_humidity rises at step 20 (moisture 100).
- Valve, sprinkler and dripper all 1 from level 128: level stays 128 for 10 steps; moisture rises 7 per step.
- Level 2, dripper=1:
  - level 1, then 0, then stays at 0.
  - moisture rises 2 per step while the pre-update level is nonzero (+2, +2), then falls 1 per step; it never underflows below 0.
- Level 0, fault_mode=1: high=1 with low=0 one cycle after fault_mode is applied; fault_mode=0 restores high=0 one cycle later.
- Freeze and reset:
  - run=0 for 20 cycles: level, moisture and the prescaler are unchanged, and step never pulses.
  - reset asserted mid-run for 1 cycle: level = INITIAL_LEVEL, moisture = 0 and all sensor outputs are 0 at the next edge.

Source files
------------

// File: rtl/water_plant_model_if.sv
// Plant-side bus: actuator commands from the irrigation controller and the
// sensor/debug readings the plant model returns.
interface water_plant_model_if #(
   parameter int LEVEL_WIDTH    = 8,
   parameter int MOISTURE_WIDTH = 8
);
   logic                      run;
   logic                      water_supply_valvule;
   logic                      splinker_bomb;
   logic                      dripper_valvule;
   logic [1:0]                fault_mode;
   logic                      low_water_level;
   logic                      mid_water_level;
   logic                      high_water_level;
   logic                      earth_humidity;
   logic                      step;
   logic [LEVEL_WIDTH-1:0]    level;
   logic [MOISTURE_WIDTH-1:0] moisture;

   modport master (
      output run, water_supply_valvule, splinker_bomb, dripper_valvule, fault_mode,
      input  low_water_level, mid_water_level, high_water_level, earth_humidity,
      input  step, level, moisture
   );

   modport slave (
      input  run, water_supply_valvule, splinker_bomb, dripper_valvule, fault_mode,
      output low_water_level, mid_water_level, high_water_level, earth_humidity,
      output step, level, moisture
   );
endinterface

// File: rtl/water_plant_model.sv
// Tank/soil plant model: level and moisture advance once per STEP_DIVIDER cycles
// while run=1; sensors are registered one cycle behind state; no backpressure.
module water_plant_model #(
   parameter int LEVEL_WIDTH     = 8,
   parameter int MOISTURE_WIDTH  = 8,
   parameter int INITIAL_LEVEL   = 0,
   parameter int LOW_THRESHOLD   = 32,
   parameter int MID_THRESHOLD   = 128,
   parameter int HIGH_THRESHOLD  = 224,
   parameter int WET_THRESHOLD   = 100,
   parameter int FILL_RATE       = 4,
   parameter int SPRINKLER_DRAIN = 3,
   parameter int DRIPPER_DRAIN   = 1,
   parameter int SPRINKLER_WET   = 5,
   parameter int DRIPPER_WET     = 2,
   parameter int DRY_RATE        = 1,
   parameter int STEP_DIVIDER    = 4
) (
   input logic clock,
   input logic reset,
   water_plant_model_if.slave bus
);
   localparam int PW = (STEP_DIVIDER > 1) ? $clog2(STEP_DIVIDER) : 1;
   localparam int LS = LEVEL_WIDTH + 2;
   localparam int MS = MOISTURE_WIDTH + 2;
   localparam logic [PW-1:0]        PRESC_LAST = PW'(STEP_DIVIDER - 1);
   localparam logic signed [LS-1:0] LEVEL_MAX  = LS'((1 << LEVEL_WIDTH) - 1);
   localparam logic [MS-1:0]        MOIST_MAX  = MS'((1 << MOISTURE_WIDTH) - 1);

   logic [PW-1:0]             presc;
   logic [LEVEL_WIDTH-1:0]    level_q;
   logic [MOISTURE_WIDTH-1:0] moist_q;
   logic                      step_q;
   logic                      low_q, mid_q, high_q, earth_q;

   logic                      step_evt;
   logic signed [LS-1:0]      lvl_sum;
   logic [LEVEL_WIDTH-1:0]    lvl_next;
   logic [MS-1:0]             wet;
   logic [MS-1:0]             moist_sum;
   logic [MOISTURE_WIDTH-1:0] moist_next;

   always_comb begin
      step_evt = bus.run && (presc == PRESC_LAST);

      // Signed with two guard bits so drains below zero and fills past max are both visible.
      lvl_sum = $signed({2'b00, level_q});
      if (bus.water_supply_valvule) lvl_sum = lvl_sum + LS'(FILL_RATE);
      if (bus.splinker_bomb)        lvl_sum = lvl_sum - LS'(SPRINKLER_DRAIN);
      if (bus.dripper_valvule)      lvl_sum = lvl_sum - LS'(DRIPPER_DRAIN);

      if (lvl_sum[LS-1])              lvl_next = '0;
      else if (lvl_sum > LEVEL_MAX)   lvl_next = '1;
      else                            lvl_next = lvl_sum[LEVEL_WIDTH-1:0];

      // An empty tank delivers no water, whatever the actuators say.
      wet = '0;
      if (level_q != '0) begin
         if (bus.splinker_bomb)   wet = wet + MS'(SPRINKLER_WET);
         if (bus.dripper_valvule) wet = wet + MS'(DRIPPER_WET);
      end

      moist_sum = {2'b00, moist_q} + wet;
      if (wet != '0)
         moist_next = (moist_sum > MOIST_MAX) ? '1 : moist_sum[MOISTURE_WIDTH-1:0];
      else if (moist_q >= MOISTURE_WIDTH'(DRY_RATE))
         moist_next = moist_q - MOISTURE_WIDTH'(DRY_RATE);
      else
         moist_next = '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         presc   <= '0;
         level_q <= LEVEL_WIDTH'(INITIAL_LEVEL);
         moist_q <= '0;
         step_q  <= 1'b0;
      end else if (bus.run) begin
         presc  <= step_evt ? '0 : presc + 1'b1;
         step_q <= step_evt;
         if (step_evt) begin
            level_q <= lvl_next;
            moist_q <= moist_next;
         end
      end else begin
         step_q <= 1'b0;
      end
   end

   // Sensors track state every cycle, independent of run; fault_mode forces one level sensor.
   always_ff @(posedge clock) begin
      if (reset) begin
         low_q   <= 1'b0;
         mid_q   <= 1'b0;
         high_q  <= 1'b0;
         earth_q <= 1'b0;
      end else begin
         low_q   <= (level_q >= LEVEL_WIDTH'(LOW_THRESHOLD))  && (bus.fault_mode != 2'd2);
         mid_q   <= (level_q >= LEVEL_WIDTH'(MID_THRESHOLD))  && (bus.fault_mode != 2'd3);
         high_q  <= (level_q >= LEVEL_WIDTH'(HIGH_THRESHOLD)) || (bus.fault_mode == 2'd1);
         earth_q <= (moist_q >= MOISTURE_WIDTH'(WET_THRESHOLD));
      end
   end

   assign bus.low_water_level  = low_q;
   assign bus.mid_water_level  = mid_q;
   assign bus.high_water_level = high_q;
   assign bus.earth_humidity   = earth_q;
   assign bus.step             = step_q;
   assign bus.level            = level_q;
   assign bus.moisture         = moist_q;
endmodule
